id_decode: RTL and testbench

ID_DECODE -- requirements
Module: id_decode

---
 rtl/id_pkg.sv | 68 ++++++
 rtl/id_ctrl_decode.sv | 133 +++++++++++++
 rtl/id_decode.sv | 193 +++++++++++++++++++
 tb/tb_id_decode.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg -- shared definitions for the instruction-decode stage.
//
// Holds the opcode and R-type funct constants of the decoded instruction set,
// the 4-bit ALU operation encoding handed to EX, the ID/EX control word
// struct with its bubble constant, and immediate-formatting helpers.
// ---------------------------------------------------------------------------
package id_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operation encoding; ALU_NOP doubles as "no legal R-type funct"
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUBU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;

    // Control word carried through the ID/EX register
    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic [4:0] dest;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE_CTRL = '{
        alu_op:    4'd0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        reg_write: 1'b0,
        illegal:   1'b0,
        dest:      5'd0
    };

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Branch displacement: sign-extended word offset converted to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] v);
        return {{14{v[15]}}, v, 2'b00};
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// ---------------------------------------------------------------------------
// id_ctrl_decode -- purely combinational opcode/funct decoder.
//
// Ports:
//   instr    in  32  instruction currently in ID
//   ctrl     out     ID/EX control word (ALU op, mem/reg enables, dest, illegal)
//   imm      out 32  formatted immediate (sext, zext for ORI, <<16 for LUI)
//   is_beq   out  1  instruction is BEQ
//   is_bne   out  1  instruction is BNE
//   is_j     out  1  instruction is J
//   uses_rs  out  1  instruction reads the rs register
//   uses_rt  out  1  instruction reads rt (R-type, SW, BEQ, BNE)
//
// The all-zero word is a canonical NOP and decodes to the bubble word with
// illegal clear; unknown opcodes or functs decode to the bubble word with
// illegal set.
// ---------------------------------------------------------------------------
module id_ctrl_decode
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl,
    output logic [31:0] imm,
    output logic        is_beq,
    output logic        is_bne,
    output logic        is_j,
    output logic        uses_rs,
    output logic        uses_rt
);

    logic [5:0] op_s;
    logic [5:0] fn_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic [3:0] r_alu_s;

    assign op_s = instr[31:26];
    assign fn_s = instr[5:0];
    assign rt_s = instr[20:16];
    assign rd_s = instr[15:11];

    // R-type funct to ALU op; ALU_NOP flags an undecoded funct
    always_comb begin
        r_alu_s = ALU_NOP;
        case (fn_s)
            FN_ADDU: r_alu_s = ALU_ADDU;
            FN_SUBU: r_alu_s = ALU_SUBU;
            FN_AND:  r_alu_s = ALU_AND;
            FN_OR:   r_alu_s = ALU_OR;
            FN_SLT:  r_alu_s = ALU_SLT;
            FN_SLL:  r_alu_s = ALU_SLL;
            default: r_alu_s = ALU_NOP;
        endcase
    end

    // Main decode: control word, immediate format and operand usage
    always_comb begin
        ctrl    = BUBBLE_CTRL;
        imm     = sext16(instr[15:0]);
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        if (instr == 32'h0000_0000) begin
            ctrl = BUBBLE_CTRL;
        end else begin
            case (op_s)
                OP_RTYPE: begin
                    if (r_alu_s != ALU_NOP) begin
                        ctrl.alu_op    = r_alu_s;
                        ctrl.dest      = rd_s;
                        ctrl.reg_write = (rd_s != 5'd0);
                        // SLL takes its source from rt; rs is a don't-care
                        uses_rs        = (fn_s != FN_SLL);
                        uses_rt        = 1'b1;
                    end else begin
                        ctrl.illegal   = 1'b1;
                    end
                end
                OP_ADDIU: begin
                    ctrl.alu_op    = ALU_ADDU;
                    ctrl.dest      = rt_s;
                    ctrl.reg_write = (rt_s != 5'd0);
                    uses_rs        = 1'b1;
                end
                OP_ORI: begin
                    ctrl.alu_op    = ALU_OR;
                    ctrl.dest      = rt_s;
                    ctrl.reg_write = (rt_s != 5'd0);
                    imm            = {16'h0000, instr[15:0]};
                    uses_rs        = 1'b1;
                end
                OP_LUI: begin
                    ctrl.alu_op    = ALU_LUI;
                    ctrl.dest      = rt_s;
                    ctrl.reg_write = (rt_s != 5'd0);
                    imm            = {instr[15:0], 16'h0000};
                end
                OP_LW: begin
                    ctrl.alu_op    = ALU_ADDU;
                    ctrl.mem_read  = 1'b1;
                    ctrl.dest      = rt_s;
                    ctrl.reg_write = (rt_s != 5'd0);
                    uses_rs        = 1'b1;
                end
                OP_SW: begin
                    ctrl.alu_op    = ALU_ADDU;
                    ctrl.mem_write = 1'b1;
                    uses_rs        = 1'b1;
                    uses_rt        = 1'b1;
                end
                OP_BEQ: begin
                    is_beq  = 1'b1;
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end
                OP_BNE: begin
                    is_bne  = 1'b1;
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end
                OP_J: begin
                    is_j = 1'b1;
                end
                default: begin
                    ctrl.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_decode.sv
// ---------------------------------------------------------------------------
// id_decode -- instruction-decode stage: hazard detection, branch resolution
// and the ID/EX pipeline register.
//
// Ports:
//   CLK, RESET                    clock (rising edge), async active-low reset
//   Instr1_PR, PCA_PR             instruction and PC+4 from IF/ID
//   FREEZE                        global hold of every register in this stage
//   RegA_data, RegB_data          register-file read data for rs / rt
//   RegA_addr, RegB_addr          rs / rt fields (combinational)
//   taken_branch1                 redirect fetch this cycle (combinational)
//   nextInstruction_address       redirect target (combinational)
//   fetchNull1                    squash the instruction now in IF (registered)
//   no_new_fetch                  load-use stall request (combinational)
//   OpA_ID, OpB_ID, Imm_ID, PCA_ID, Dest_ID, ALUop_ID,
//   MemRead_ID, MemWrite_ID, RegWrite_ID, Illegal_ID   ID/EX register outputs
//
// Build option: ID_LOAD_USE_STALL_EN enables load-use interlocking. When it
// is not defined no_new_fetch stays 0 and software must schedule load delays.
//
// There is no delay slot: a redirect sets fetchNull1 for the next cycle and
// the instruction in ID during that cycle is replaced by a bubble. Branches
// are suppressed while squashing, stalling or frozen so a redirect is never
// issued for an instruction that is not actually moving forward.
// ---------------------------------------------------------------------------
module id_decode
    import id_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_PR,
    input  logic [31:0] PCA_PR,
    input  logic        FREEZE,
    input  logic [31:0] RegA_data,
    input  logic [31:0] RegB_data,
    output logic [4:0]  RegA_addr,
    output logic [4:0]  RegB_addr,
    output logic        taken_branch1,
    output logic [31:0] nextInstruction_address,
    output logic        fetchNull1,
    output logic        no_new_fetch,
    output logic [31:0] OpA_ID,
    output logic [31:0] OpB_ID,
    output logic [31:0] Imm_ID,
    output logic [31:0] PCA_ID,
    output logic [4:0]  Dest_ID,
    output logic [3:0]  ALUop_ID,
    output logic        MemRead_ID,
    output logic        MemWrite_ID,
    output logic        RegWrite_ID,
    output logic        Illegal_ID
);

`ifdef ID_LOAD_USE_STALL_EN
    localparam logic LOAD_USE_EN = 1'b1;
`else
    localparam logic LOAD_USE_EN = 1'b0;
`endif

    // Decoder outputs
    ctrl_word_t  dec_ctrl_s;
    logic [31:0] dec_imm_s;
    logic        is_beq_s;
    logic        is_bne_s;
    logic        is_j_s;
    logic        uses_rs_s;
    logic        uses_rt_s;

    // Hazard / branch nets
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic        hazard_match_s;
    logic        load_use_s;
    logic        regs_equal_s;
    logic        branch_cond_s;
    logic        taken_s;
    logic        bubble_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] target_s;

    // Pipeline state
    ctrl_word_t  ctrl_r;
    logic [31:0] opa_r;
    logic [31:0] opb_r;
    logic [31:0] imm_r;
    logic [31:0] pca_r;
    logic        fetch_null_r;

    id_ctrl_decode u_ctrl_decode (
        .instr   (Instr1_PR),
        .ctrl    (dec_ctrl_s),
        .imm     (dec_imm_s),
        .is_beq  (is_beq_s),
        .is_bne  (is_bne_s),
        .is_j    (is_j_s),
        .uses_rs (uses_rs_s),
        .uses_rt (uses_rt_s)
    );

    assign rs_s = Instr1_PR[25:21];
    assign rt_s = Instr1_PR[20:16];

    // Load in EX whose destination feeds the instruction in ID. An
    // instruction being squashed never requests a stall: holding IF/ID would
    // let it re-enter ID once fetchNull1 has dropped.
    always_comb begin
        hazard_match_s = 1'b0;
        if (ctrl_r.mem_read && (ctrl_r.dest != 5'd0) && !fetch_null_r) begin
            hazard_match_s = (uses_rs_s && (rs_s == ctrl_r.dest)) ||
                             (uses_rt_s && (rt_s == ctrl_r.dest));
        end else begin
            hazard_match_s = 1'b0;
        end
    end

    assign load_use_s = hazard_match_s & LOAD_USE_EN;

    // Branch condition and redirect qualification
    always_comb begin
        regs_equal_s  = (RegA_data == RegB_data);
        branch_cond_s = (is_beq_s & regs_equal_s) |
                        (is_bne_s & ~regs_equal_s) |
                        is_j_s;
        taken_s       = branch_cond_s & ~load_use_s & ~FREEZE & ~fetch_null_r;
        bubble_s      = fetch_null_r | load_use_s;
    end

    // Redirect target: 32-bit wrapping branch add, or region-relative jump
    always_comb begin
        br_target_s = PCA_PR + branch_offset(Instr1_PR[15:0]);
        j_target_s  = {PCA_PR[31:28], Instr1_PR[25:0], 2'b00};
        if (is_j_s) begin
            target_s = j_target_s;
        end else begin
            target_s = br_target_s;
        end
    end

    // Squash flag: set for exactly the cycle after a redirect, held by FREEZE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_null_r <= 1'b0;
        end else if (!FREEZE) begin
            fetch_null_r <= taken_s;
        end
    end

    // ID/EX register: loads decoded instruction, or an all-zero bubble while
    // squashing or stalling; held entirely by FREEZE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_r <= BUBBLE_CTRL;
            opa_r  <= 32'h0000_0000;
            opb_r  <= 32'h0000_0000;
            imm_r  <= 32'h0000_0000;
            pca_r  <= 32'h0000_0000;
        end else if (!FREEZE) begin
            if (bubble_s) begin
                ctrl_r <= BUBBLE_CTRL;
                opa_r  <= 32'h0000_0000;
                opb_r  <= 32'h0000_0000;
                imm_r  <= 32'h0000_0000;
                pca_r  <= 32'h0000_0000;
            end else begin
                ctrl_r <= dec_ctrl_s;
                opa_r  <= RegA_data;
                opb_r  <= RegB_data;
                imm_r  <= dec_imm_s;
                pca_r  <= PCA_PR;
            end
        end
    end

    assign RegA_addr               = rs_s;
    assign RegB_addr               = rt_s;
    assign taken_branch1           = taken_s;
    assign nextInstruction_address = target_s;
    assign no_new_fetch            = load_use_s;
    assign fetchNull1              = fetch_null_r;

    assign OpA_ID      = opa_r;
    assign OpB_ID      = opb_r;
    assign Imm_ID      = imm_r;
    assign PCA_ID      = pca_r;
    assign Dest_ID     = ctrl_r.dest;
    assign ALUop_ID    = ctrl_r.alu_op;
    assign MemRead_ID  = ctrl_r.mem_read;
    assign MemWrite_ID = ctrl_r.mem_write;
    assign RegWrite_ID = ctrl_r.reg_write;
    assign Illegal_ID  = ctrl_r.illegal;

endmodule

// File: tb/tb_id_decode.sv
// ---------------------------------------------------------------------------
// tb_id_decode -- directed self-checking bench for id_decode.
// The bench plays the IF/ID register: inputs change 1 ns after a rising
// edge, registered outputs are checked 1 ns after the edge that loads them,
// combinational outputs 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_id_decode;

    logic        CLK;
    logic        RESET;
    logic [31:0] Instr1_PR;
    logic [31:0] PCA_PR;
    logic        FREEZE;
    logic [31:0] RegA_data;
    logic [31:0] RegB_data;
    logic [4:0]  RegA_addr;
    logic [4:0]  RegB_addr;
    logic        taken_branch1;
    logic [31:0] nextInstruction_address;
    logic        fetchNull1;
    logic        no_new_fetch;
    logic [31:0] OpA_ID;
    logic [31:0] OpB_ID;
    logic [31:0] Imm_ID;
    logic [31:0] PCA_ID;
    logic [4:0]  Dest_ID;
    logic [3:0]  ALUop_ID;
    logic        MemRead_ID;
    logic        MemWrite_ID;
    logic        RegWrite_ID;
    logic        Illegal_ID;

    int n_vec = 0;
    int n_err = 0;

    // Expected ALU encodings
    localparam logic [31:0] A_NOP = 32'd0, A_ADDU = 32'd1, A_SUBU = 32'd2, A_AND = 32'd3;
    localparam logic [31:0] A_OR = 32'd4, A_SLT = 32'd5, A_SLL = 32'd6, A_LUI = 32'd7;

    id_decode dut (
        .CLK(CLK), .RESET(RESET), .Instr1_PR(Instr1_PR), .PCA_PR(PCA_PR),
        .FREEZE(FREEZE), .RegA_data(RegA_data), .RegB_data(RegB_data),
        .RegA_addr(RegA_addr), .RegB_addr(RegB_addr),
        .taken_branch1(taken_branch1),
        .nextInstruction_address(nextInstruction_address),
        .fetchNull1(fetchNull1), .no_new_fetch(no_new_fetch),
        .OpA_ID(OpA_ID), .OpB_ID(OpB_ID), .Imm_ID(Imm_ID), .PCA_ID(PCA_ID),
        .Dest_ID(Dest_ID), .ALUop_ID(ALUop_ID), .MemRead_ID(MemRead_ID),
        .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID),
        .Illegal_ID(Illegal_ID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction, clock it into ID/EX and check the decoded fields
    task automatic run_vec(input string name, input logic [31:0] instr, input logic [31:0] pca,
                           input logic [31:0] dest, input logic [31:0] imm, input logic [31:0] alu,
                           input logic [31:0] mr, input logic [31:0] mw, input logic [31:0] rw,
                           input logic [31:0] ill);
        Instr1_PR = instr;
        PCA_PR    = pca;
        tick();
        chk({name, ".dest"}, {27'd0, Dest_ID}, dest);
        chk({name, ".imm"}, Imm_ID, imm);
        chk({name, ".alu"}, {28'd0, ALUop_ID}, alu);
        chk({name, ".mr"}, {31'd0, MemRead_ID}, mr);
        chk({name, ".mw"}, {31'd0, MemWrite_ID}, mw);
        chk({name, ".rw"}, {31'd0, RegWrite_ID}, rw);
        chk({name, ".ill"}, {31'd0, Illegal_ID}, ill);
        chk({name, ".pca"}, PCA_ID, pca);
    endtask

    initial begin
        // ---------------- reset ----------------
        RESET = 1'b0; FREEZE = 1'b0;
        Instr1_PR = 32'h2401_0005; PCA_PR = 32'h0000_0004;
        RegA_data = 32'h0000_0011; RegB_data = 32'h0000_0022;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.dest", {27'd0, Dest_ID}, 32'd0);
        chk("rst.imm", Imm_ID, 32'd0);
        chk("rst.rw", {31'd0, RegWrite_ID}, 32'd0);
        chk("rst.opa", OpA_ID, 32'd0);
        chk("rst.pca", PCA_ID, 32'd0);
        chk("rst.fnull", {31'd0, fetchNull1}, 32'd0);
        chk("rst.ill", {31'd0, Illegal_ID}, 32'd0);
        chk("rst.rb_addr", {27'd0, RegB_addr}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        chk("post_rst.dest", {27'd0, Dest_ID}, 32'd1);
        chk("post_rst.imm", Imm_ID, 32'd5);
        chk("post_rst.rw", {31'd0, RegWrite_ID}, 32'd1);
        chk("post_rst.opa", OpA_ID, 32'h11);
        chk("post_rst.opb", OpB_ID, 32'h22);

        // ---------------- decode table ----------------
        //       name     instr          pca           dest imm            alu     mr mw rw ill
        run_vec("addiu",  32'h2401_0005, 32'h1000, 1, 32'h0000_0005, A_ADDU, 0, 0, 1, 0);
        run_vec("addneg", 32'h2422_FFFF, 32'h1004, 2, 32'hFFFF_FFFF, A_ADDU, 0, 0, 1, 0);
        run_vec("ori",    32'h3425_8000, 32'h1008, 5, 32'h0000_8000, A_OR,   0, 0, 1, 0);
        run_vec("lui",    32'h3C03_1234, 32'h100C, 3, 32'h1234_0000, A_LUI,  0, 0, 1, 0);
        run_vec("subu",   32'h0022_2023, 32'h1010, 4, 32'h0000_2023, A_SUBU, 0, 0, 1, 0);
        run_vec("and",    32'h0022_2024, 32'h1014, 4, 32'h0000_2024, A_AND,  0, 0, 1, 0);
        run_vec("slt",    32'h0022_202A, 32'h1018, 4, 32'h0000_202A, A_SLT,  0, 0, 1, 0);
        run_vec("sll",    32'h0002_2100, 32'h101C, 4, 32'h0000_2100, A_SLL,  0, 0, 1, 0);
        run_vec("addu0",  32'h0020_0021, 32'h1020, 0, 32'h0000_0021, A_ADDU, 0, 0, 0, 0);
        run_vec("sw",     32'hAC22_0004, 32'h1024, 0, 32'h0000_0004, A_ADDU, 0, 1, 0, 0);
        run_vec("lw",     32'h8C22_0008, 32'h1028, 2, 32'h0000_0008, A_ADDU, 1, 0, 1, 0);
        run_vec("nop",    32'h0000_0000, 32'h102C, 0, 32'h0000_0000, A_NOP,  0, 0, 0, 0);
        run_vec("illop",  32'hFC00_0000, 32'h1030, 0, 32'h0000_0000, A_NOP,  0, 0, 0, 1);
        run_vec("illfn",  32'h0000_003F, 32'h1034, 0, 32'h0000_003F, A_NOP,  0, 0, 0, 1);

        // ---------------- BEQ taken, squash of following instruction ----------------
        RegA_data = 32'd7; RegB_data = 32'd7;
        Instr1_PR = 32'h1022_0003; PCA_PR = 32'h0000_0100;
        #1;
        chk("beq.taken", {31'd0, taken_branch1}, 32'd1);
        chk("beq.target", nextInstruction_address, 32'h0000_010C);
        tick();
        chk("beq.fnull", {31'd0, fetchNull1}, 32'd1);
        Instr1_PR = 32'h3C03_1234; PCA_PR = 32'h0000_0104;
        tick();
        chk("beq.sq_dest", {27'd0, Dest_ID}, 32'd0);
        chk("beq.sq_rw", {31'd0, RegWrite_ID}, 32'd0);
        chk("beq.sq_alu", {28'd0, ALUop_ID}, A_NOP);
        chk("beq.fnull_off", {31'd0, fetchNull1}, 32'd0);

        // ---------------- BNE not taken / taken with negative offset ----------------
        Instr1_PR = 32'h1422_0003;
        #1;
        chk("bne_eq.taken", {31'd0, taken_branch1}, 32'd0);
        tick();
        chk("bne_eq.fnull", {31'd0, fetchNull1}, 32'd0);
        RegB_data = 32'd8;
        Instr1_PR = 32'h1422_FFFF; PCA_PR = 32'h0000_0200;
        #1;
        chk("bne.taken", {31'd0, taken_branch1}, 32'd1);
        chk("bne.target", nextInstruction_address, 32'h0000_01FC);
        tick();
        // a jump sitting in ID while squashing must not redirect
        Instr1_PR = 32'h0800_0010;
        #1;
        chk("sq_j.taken", {31'd0, taken_branch1}, 32'd0);
        FREEZE = 1'b1;
        tick();
        chk("frz_fnull1", {31'd0, fetchNull1}, 32'd1);
        tick();
        chk("frz_fnull2", {31'd0, fetchNull1}, 32'd1);
        FREEZE = 1'b0;
        tick();
        chk("frz_fnull_off", {31'd0, fetchNull1}, 32'd0);

        // ---------------- J wrap and FREEZE gating ----------------
        Instr1_PR = 32'h0BFF_FFFF; PCA_PR = 32'hF000_0004;
        FREEZE = 1'b1;
        #1;
        chk("j.frz_taken", {31'd0, taken_branch1}, 32'd0);
        FREEZE = 1'b0;
        #1;
        chk("j.taken", {31'd0, taken_branch1}, 32'd1);
        chk("j.target", nextInstruction_address, 32'hFFFF_FFFC);
        tick();
        chk("j.fnull", {31'd0, fetchNull1}, 32'd1);
        Instr1_PR = 32'h0000_0000;
        tick();
        chk("j.fnull_off", {31'd0, fetchNull1}, 32'd0);

        // ---------------- load-use ----------------
        RegA_data = 32'd0; RegB_data = 32'd0;
        Instr1_PR = 32'h8C02_0000; PCA_PR = 32'h0000_0300;
        tick();
        chk("lu.lw_mr", {31'd0, MemRead_ID}, 32'd1);
        Instr1_PR = 32'h0041_1821; PCA_PR = 32'h0000_0304;
        #1;
`ifdef ID_LOAD_USE_STALL_EN
        chk("lu.stall", {31'd0, no_new_fetch}, 32'd1);
        tick();
        chk("lu.bub_dest", {27'd0, Dest_ID}, 32'd0);
        chk("lu.bub_mr", {31'd0, MemRead_ID}, 32'd0);
        chk("lu.stall_off", {31'd0, no_new_fetch}, 32'd0);
`else
        chk("lu.nostall", {31'd0, no_new_fetch}, 32'd0);
`endif
        tick();
        chk("lu.addu_dest", {27'd0, Dest_ID}, 32'd3);
        chk("lu.addu_rw", {31'd0, RegWrite_ID}, 32'd1);
        chk("lu.addu_alu", {28'd0, ALUop_ID}, A_ADDU);

        // LUI writes rt but does not read it: no interlock
        Instr1_PR = 32'h8C02_0000;
        tick();
        Instr1_PR = 32'h3C02_0001;
        #1;
        chk("lu.lui_nostall", {31'd0, no_new_fetch}, 32'd0);
        tick();
        chk("lu.lui_dest", {27'd0, Dest_ID}, 32'd2);

        // ---------------- FREEZE during a stall ----------------
        Instr1_PR = 32'h8C02_0000;
        tick();
        Instr1_PR = 32'h0041_1821;
        FREEZE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                RegA_data = 32'd7; RegB_data = 32'd7;
                Instr1_PR = 32'h1022_0003;
            end
            tick();
            chk("frz.dest", {27'd0, Dest_ID}, 32'd2);
            chk("frz.mr", {31'd0, MemRead_ID}, 32'd1);
            chk("frz.fnull", {31'd0, fetchNull1}, 32'd0);
            chk("frz.taken", {31'd0, taken_branch1}, 32'd0);
        end
        Instr1_PR = 32'h0041_1821;
        FREEZE = 1'b0;
`ifdef ID_LOAD_USE_STALL_EN
        tick();
        chk("frz.bub_dest", {27'd0, Dest_ID}, 32'd0);
`endif
        tick();
        chk("frz.addu_dest", {27'd0, Dest_ID}, 32'd3);

        // ---------------- reset mid-stall ----------------
        Instr1_PR = 32'h8C02_0000;
        tick();
        Instr1_PR = 32'h0041_1821;
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_stall.nnf", {31'd0, no_new_fetch}, 32'd0);
        chk("rst_stall.mr", {31'd0, MemRead_ID}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        chk("rst_stall.dest", {27'd0, Dest_ID}, 32'd3);

        // ---------------- reset mid-squash ----------------
        RegA_data = 32'd7; RegB_data = 32'd7;
        Instr1_PR = 32'h1022_0003; PCA_PR = 32'h0000_0100;
        tick();
        chk("rst_sq.fnull", {31'd0, fetchNull1}, 32'd1);
        Instr1_PR = 32'h3C03_1234;
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_sq.fnull_clr", {31'd0, fetchNull1}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        chk("rst_sq.dest", {27'd0, Dest_ID}, 32'd3);
        chk("rst_sq.rw", {31'd0, RegWrite_ID}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
